// File: rtl/sn_queued_pkg.sv
// Shared types and constants for the queued subordinate node.
package sn_queued_pkg;

    localparam int ADDR_BITS  = 5;
    localparam int WORD_WIDTH = 8;

    typedef enum logic [2:0] {
        op_nop       = 3'd0,
        op_read      = 3'd1,
        op_write     = 3'd2,
        op_data_recv = 3'd3,
        op_write_ack = 3'd4,
        op_addr_err  = 3'd5
    } Type_opcode;

    typedef struct packed {
        Type_opcode              opcode;
        logic [ADDR_BITS-1:0]    addr;
        logic [WORD_WIDTH-1:0]   data;
    } ReqType;

    typedef struct packed {
        Type_opcode              opcode;
        logic [ADDR_BITS-1:0]    addr;
        logic [WORD_WIDTH-1:0]   data;
    } DataType;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAsserted = 2'd1,
        StExec     = 2'd2,
        StPre      = 2'd3
    } Type_chn_state;

    // True when addr names a word that exists in a memory of 'depth' words.
    function automatic logic in_range(input logic [ADDR_BITS-1:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/sn_req_fifo.sv
// Synchronous request FIFO; pointers wrap modulo QDEPTH so any depth >= 2 works.
module sn_req_fifo
    import sn_queued_pkg::*;
#(
    parameter int QDEPTH = 4,
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  ReqType        din,
    input  logic          pop,
    output ReqType        dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    ReqType          store [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count != CW'(QDEPTH));
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign dout    = store[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sn_queued.sv
// Subordinate node: queues requests, executes them in order against a local
// register-file memory and returns one response per request.
// Handshake: the sender raises pre_* one cycle ahead of a single-cycle v_*;
// a payload is only meaningful in the cycle its v_* is high.
module sn_queued
    import sn_queued_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int QDEPTH   = 4,
    parameter int READ_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    pre_rx_req,
    input  ReqType  rx_req,
    input  logic    v_rx_req,
    output logic    rx_full,
    output logic    pre_tx_data,
    output DataType tx_data,
    output logic    v_tx_data,
    input  logic    tx_hold,
    output logic    proto_err
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    Type_chn_state          rx_state;
    Type_chn_state          tx_state;
    logic                   push;
    logic                   pop;
    logic                   announce_ok;
    logic                   pending_next;
    logic [CW:0]            occ_next;
    logic [CW-1:0]          count;
    logic                   empty;
    ReqType                 head;
    logic                   head_ok;
    logic [IW-1:0]          head_idx;
    DataType                exec_res;
    DataType                result;
    logic [LW-1:0]          lat_cnt;
    logic                   exec_last;
    logic                   mem_we;
    logic [WORD_WIDTH-1:0]  mem [DEPTH];

    // A request is accepted only when it follows an announce; a new announce
    // while full is refused so the pending slot never overflows the queue.
    assign push         = v_rx_req && (rx_state == StAsserted);
    assign pop          = (tx_state == StAsserted);
    assign announce_ok  = pre_rx_req && !rx_full;
    assign pending_next = ((rx_state == StAsserted) && !v_rx_req) || announce_ok;
    assign occ_next     = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop) + (CW+1)'(pending_next);

    sn_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (rx_req),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    // Rx FSM: tracks an outstanding announce, registers rx_full, latches errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= StIdle;
            rx_full   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            rx_state <= pending_next ? StAsserted : StIdle;
            rx_full  <= (occ_next >= (CW+1)'(QDEPTH));
            if ((v_rx_req && (rx_state == StIdle)) || (pre_rx_req && rx_full))
                proto_err <= 1'b1;
        end
    end

    assign head_ok   = in_range(head.addr, DEPTH);
    assign head_idx  = head.addr[IW-1:0];
    assign exec_last = (tx_state == StExec) && (lat_cnt == '0);
    assign mem_we    = exec_last && (head.opcode == op_write) && head_ok;

    // Response for the queue head; out-of-range or unknown opcodes never touch memory.
    always_comb begin
        exec_res      = '0;
        exec_res.addr = head.addr;
        if ((head.opcode == op_read) && head_ok) begin
            exec_res.opcode = op_data_recv;
            exec_res.data   = mem[head_idx];
        end else if ((head.opcode == op_write) && head_ok) begin
            exec_res.opcode = op_write_ack;
        end else begin
            exec_res.opcode = op_addr_err;
        end
    end

    // Memory: word i resets to i; writes land on the final execute cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= WORD_WIDTH'(i);
        end else if (mem_we) begin
            mem[head_idx] <= head.data;
        end
    end

    // Tx FSM: execute for READ_LAT cycles, announce, then emit and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state    <= StIdle;
            lat_cnt     <= '0;
            result      <= '0;
            pre_tx_data <= 1'b0;
            v_tx_data   <= 1'b0;
            tx_data     <= '0;
        end else begin
            case (tx_state)
                StIdle: begin
                    if (!empty || push) begin
                        tx_state <= StExec;
                        lat_cnt  <= LW'(READ_LAT - 1);
                    end
                end
                StExec: begin
                    if (lat_cnt == '0) begin
                        result      <= exec_res;
                        pre_tx_data <= 1'b1;
                        tx_state    <= StPre;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                StPre: begin
                    if (!tx_hold) begin
                        pre_tx_data <= 1'b0;
                        v_tx_data   <= 1'b1;
                        tx_data     <= result;
                        tx_state    <= StAsserted;
                    end
                end
                StAsserted: begin
                    v_tx_data <= 1'b0;
                    tx_data   <= '0;
                    if ((count > CW'(1)) || push) begin
                        tx_state <= StExec;
                        lat_cnt  <= LW'(READ_LAT - 1);
                    end else begin
                        tx_state <= StIdle;
                    end
                end
                default: tx_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sn_queued.sv
// Bench for sn_queued: directed timing sequences, a vector table, randomized
// traffic against a reference model, and a READ_LAT=3 throughput instance.
module tb_sn_queued;
    import sn_queued_pkg::*;

    localparam int DEPTH  = 16;
    localparam int QDEPTH = 4;
    localparam int W      = $bits(DataType);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: READ_LAT=1
    logic    a_pre = 1'b0, a_v = 1'b0, a_hold = 1'b0;
    ReqType  a_req = '0;
    logic    a_full, a_pre_tx, a_vtx, a_perr;
    DataType a_tx;
    // Instance b: READ_LAT=3
    logic    b_pre = 1'b0, b_v = 1'b0, b_hold = 1'b0;
    ReqType  b_req = '0;
    logic    b_full, b_pre_tx, b_vtx, b_perr;
    DataType b_tx;

    sn_queued #(.DEPTH(DEPTH), .QDEPTH(QDEPTH), .READ_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .pre_rx_req(a_pre), .rx_req(a_req), .v_rx_req(a_v),
        .rx_full(a_full), .pre_tx_data(a_pre_tx), .tx_data(a_tx), .v_tx_data(a_vtx),
        .tx_hold(a_hold), .proto_err(a_perr)
    );

    sn_queued #(.DEPTH(DEPTH), .QDEPTH(QDEPTH), .READ_LAT(3)) u_dut_lat3 (
        .clk(clk), .reset(reset), .pre_rx_req(b_pre), .rx_req(b_req), .v_rx_req(b_v),
        .rx_full(b_full), .pre_tx_data(b_pre_tx), .tx_data(b_tx), .v_tx_data(b_vtx),
        .tx_hold(b_hold), .proto_err(b_perr)
    );

    int checks = 0;
    int errors = 0;
    logic rand_hold = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_b_q[$];
    int           b_times[$];
    int           model_mem [DEPTH];
    int           a_resp = 0;
    logic         a_prev_pre = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=timeout exp=event", name);
    endtask

    function automatic ReqType mk_req(input Type_opcode op, input int addr, input int data);
        ReqType r;
        r.opcode = op;
        r.addr   = ADDR_BITS'(addr);
        r.data   = WORD_WIDTH'(data);
        return r;
    endfunction

    function automatic DataType mk_rsp(input Type_opcode op, input int addr, input int data);
        DataType d;
        d.opcode = op;
        d.addr   = ADDR_BITS'(addr);
        d.data   = WORD_WIDTH'(data);
        return d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = i;
    endfunction

    // Reference: requests complete in arrival order against a flat word array.
    function automatic DataType predict(input ReqType r);
        int a;
        a = int'(r.addr);
        if (a >= DEPTH || !(r.opcode inside {op_read, op_write}))
            return mk_rsp(op_addr_err, a, 0);
        if (r.opcode == op_read)
            return mk_rsp(op_data_recv, a, model_mem[a] % 256);
        model_mem[a] = int'(r.data);
        return mk_rsp(op_write_ack, a, 0);
    endfunction

    // Scoreboard for instance a: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && a_vtx) begin
            a_resp++;
            check("a_pre_before_v", 64'(a_prev_pre), 64'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_resp got=%0h exp=none", a_tx);
            end else begin
                check("a_resp", 64'(a_tx), 64'(exp_q.pop_front()));
            end
        end
        a_prev_pre = a_pre_tx;
    end

    // Scoreboard for instance b, also stamping each response cycle.
    always @(negedge clk) begin
        if (!reset && b_vtx) begin
            b_times.push_back(cyc);
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_resp got=%0h exp=none", b_tx);
            end else begin
                check("b_resp", 64'(b_tx), 64'(exp_b_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_hold) a_hold = ($urandom_range(0, 3) == 0);
    endtask

    // Announce, then present the request one cycle later; t_v is the valid cycle.
    task automatic send_a(input ReqType r, output int t_v);
        int g;
        g = 0;
        while (a_full && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) fail_now("a_full_wait");
        a_pre = 1'b1;
        tick();
        a_pre = 1'b0;
        a_v   = 1'b1;
        a_req = r;
        t_v   = cyc;
        exp_q.push_back(predict(r));
        tick();
        a_v = 1'b0;
    endtask

    task automatic drain_a();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            tick();
            g++;
        end
        if (g >= 400) fail_now("a_drain");
        tick();
    endtask

    task automatic wait_v_a(output DataType got);
        int g;
        g = 0;
        while (!a_vtx && g < 30) begin
            tick();
            g++;
        end
        if (!a_vtx) fail_now("a_wait_v");
        got = a_tx;
        tick();
    endtask

    typedef struct {
        Type_opcode op;
        int         addr;
        int         data;
        Type_opcode exp_op;
        int         exp_data;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int      t;
        int      base;
        DataType got;
        ReqType  rr;
        int      sel;

        vecs[0] = '{op_read,   0,  0,    op_data_recv, 8'h00};
        vecs[1] = '{op_read,   15, 0,    op_data_recv, 8'h0F};
        vecs[2] = '{op_write,  9,  8'h5A, op_write_ack, 0};
        vecs[3] = '{op_read,   9,  0,    op_data_recv, 8'h5A};
        vecs[4] = '{op_read,   16, 0,    op_addr_err,  0};
        vecs[5] = '{op_read,   0,  0,    op_data_recv, 8'h00};
        vecs[6] = '{op_write,  31, 8'h11, op_addr_err,  0};
        vecs[7] = '{op_nop,    2,  8'h22, op_addr_err,  0};
        vecs[8] = '{op_write,  0,  8'hFF, op_write_ack, 0};
        vecs[9] = '{op_read,   0,  0,    op_data_recv, 8'hFF};

        // Reset values
        model_reset();
        repeat (3) tick();
        check("rst_rx_full", 64'(a_full), 64'd0);
        check("rst_pre_tx", 64'(a_pre_tx), 64'd0);
        check("rst_v_tx", 64'(a_vtx), 64'd0);
        check("rst_tx_data", 64'(a_tx), 64'd0);
        check("rst_proto_err", 64'(a_perr), 64'd0);
        reset = 1'b0;
        tick();

        // Read addr 5: pre at T+2, v at T+3
        send_a(mk_req(op_read, 5, 0), t);
        check("rd5_pre_T1", 64'(a_pre_tx), 64'd0);
        tick();
        check("rd5_pre_T2", 64'(a_pre_tx), 64'd1);
        check("rd5_v_T2", 64'(a_vtx), 64'd0);
        tick();
        check("rd5_v_T3", 64'(a_vtx), 64'd1);
        check("rd5_data", 64'(a_tx), 64'(mk_rsp(op_data_recv, 5, 5)));
        drain_a();

        // Write then immediate read of the same address
        base = a_resp;
        send_a(mk_req(op_write, 3, 8'hA5), t);
        send_a(mk_req(op_read, 3, 0), t);
        drain_a();
        check("raw_resp_count", 64'(a_resp - base), 64'd2);

        // Vector table against hand-derived expectations
        for (int i = 0; i < 10; i++) begin
            send_a(mk_req(vecs[i].op, vecs[i].addr, vecs[i].data), t);
            wait_v_a(got);
            check($sformatf("vec%0d_op", i), 64'(got.opcode), 64'(vecs[i].exp_op));
            check($sformatf("vec%0d_addr", i), 64'(got.addr), 64'(vecs[i].addr % 32));
            check($sformatf("vec%0d_data", i), 64'(got.data), 64'(vecs[i].exp_data));
        end
        drain_a();

        // Queue fill under back-pressure, dropped fifth announce
        a_hold = 1'b1;
        base = a_resp;
        send_a(mk_req(op_read, 1, 0), t);
        send_a(mk_req(op_read, 2, 0), t);
        send_a(mk_req(op_read, 8, 0), t);
        send_a(mk_req(op_read, 15, 0), t);
        check("full_after_4", 64'(a_full), 64'd1);
        check("no_err_before_5th", 64'(a_perr), 64'd0);
        a_pre = 1'b1;
        tick();
        a_pre = 1'b0;
        check("err_on_5th", 64'(a_perr), 64'd1);
        repeat (4) tick();
        check("held_no_resp", 64'(a_resp - base), 64'd0);
        a_hold = 1'b0;
        drain_a();
        repeat (3) tick();
        check("drained_four", 64'(a_resp - base), 64'd4);
        check("full_cleared", 64'(a_full), 64'd0);
        check("err_sticky", 64'(a_perr), 64'd1);

        // Reset during execute
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        check("err_cleared_by_rst", 64'(a_perr), 64'd0);
        a_v = 1'b1;
        tick();
        a_v = 1'b0;
        check("v_in_idle_err", 64'(a_perr), 64'd1);
        send_a(mk_req(op_write, 4, 8'h3C), t);
        drain_a();
        base = a_resp;
        send_a(mk_req(op_read, 7, 0), t);
        reset = 1'b1;
        #1;
        check("midrst_rx_full", 64'(a_full), 64'd0);
        check("midrst_pre_tx", 64'(a_pre_tx), 64'd0);
        check("midrst_v_tx", 64'(a_vtx), 64'd0);
        check("midrst_tx_data", 64'(a_tx), 64'd0);
        check("midrst_proto_err", 64'(a_perr), 64'd0);
        exp_q.delete();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("midrst_no_stray", 64'(a_resp - base), 64'd0);
        send_a(mk_req(op_read, 4, 0), t);
        wait_v_a(got);
        check("mem_reinit", 64'(got), 64'(mk_rsp(op_data_recv, 4, 4)));
        drain_a();

        // Randomized traffic against the reference model
        rand_hold = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            rr = mk_req((sel < 5) ? op_read : (sel < 9) ? op_write : op_nop,
                        $urandom_range(0, 19), $urandom_range(0, 255));
            send_a(rr, t);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_hold = 1'b0;
        a_hold = 1'b0;
        drain_a();
        check("rand_no_proto_err", 64'(a_perr), 64'd0);

        // READ_LAT=3: back-to-back requests, responses every 5 cycles
        exp_b_q.push_back(mk_rsp(op_data_recv, 6, 6));
        exp_b_q.push_back(mk_rsp(op_data_recv, 10, 10));
        exp_b_q.push_back(mk_rsp(op_addr_err, 16, 0));
        b_pre = 1'b1;
        tick();
        b_v = 1'b1;
        b_req = mk_req(op_read, 6, 0);
        t = cyc;
        tick();
        b_req = mk_req(op_read, 10, 0);
        tick();
        b_pre = 1'b0;
        b_req = mk_req(op_read, 16, 0);
        tick();
        b_v = 1'b0;
        begin
            int g;
            g = 0;
            while (b_times.size() < 3 && g < 60) begin
                tick();
                g++;
            end
        end
        if (b_times.size() == 3) begin
            check("b_first_latency", 64'(b_times[0] - t), 64'd5);
            check("b_gap_1", 64'(b_times[1] - b_times[0]), 64'd5);
            check("b_gap_2", 64'(b_times[2] - b_times[1]), 64'd5);
        end else begin
            fail_now("b_three_responses");
        end
        check("b_no_proto_err", 64'(b_perr), 64'd0);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
